// File: rtl/board_renderer_pkg.sv
// Shared definitions for the checkers board renderer: square codes,
// palette, frame/board geometry and FSM state encoding.
package board_renderer_pkg;

  // Frame and board geometry in virtual pixels.
  localparam int FRAME_W  = 160;
  localparam int FRAME_H  = 120;
  localparam int BOARD_X0 = 20;
  localparam int SQ       = 15;
  localparam int DISC_R2  = 25;

  // Sized forms of the geometry used by the counters and comparators.
  localparam logic [7:0]  X_MAX      = 8'(FRAME_W - 1);
  localparam logic [6:0]  Y_MAX      = 7'(FRAME_H - 1);
  localparam logic [7:0]  X_BOARD_LO = 8'(BOARD_X0);
  localparam logic [7:0]  X_BOARD_HI = 8'(BOARD_X0 + 8 * SQ - 1);
  localparam logic [3:0]  SQ_MAX     = 4'(SQ - 1);
  localparam logic [14:0] PIX_LAST   = 15'(FRAME_W * FRAME_H - 1);

  // Disc centre and king-crown window in square-local coordinates.
  localparam logic [3:0] DISC_C   = 4'd7;
  localparam logic [3:0] CROWN_LO = 4'd6;
  localparam logic [3:0] CROWN_HI = 4'd8;

  typedef enum logic [2:0] {
    SQ_LIGHT   = 3'b000,
    SQ_P1_MAN  = 3'b001,
    SQ_P2_MAN  = 3'b010,
    SQ_P1_KING = 3'b011,
    SQ_P2_KING = 3'b100,
    SQ_RSVD_5  = 3'b101,
    SQ_RSVD_6  = 3'b110,
    SQ_DARK    = 3'b111
  } sq_code_e;

  // RGB888 palette.
  localparam logic [23:0] COL_BLACK = 24'h000000;
  localparam logic [23:0] COL_LIGHT = 24'hF0D9B5;
  localparam logic [23:0] COL_DARK  = 24'h769656;
  localparam logic [23:0] COL_P1    = 24'hFF0000;
  localparam logic [23:0] COL_P2    = 24'hFFFFFF;
  localparam logic [23:0] COL_RSVD  = 24'hFF00FF;
  localparam logic [23:0] COL_KING  = 24'hFFD700;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/board_renderer_pixel_shader.sv
// Combinational pixel colouring: square code plus square-local coordinates
// in, RGB888 out. Pixels outside the board area are black.
module board_pixel_shader
  import board_renderer_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [3:0]  lx,
  input  logic [3:0]  ly,
  input  logic        in_board,
  output logic [23:0] pix_rgb
);

  logic [3:0] dx;
  logic [3:0] dy;
  logic [7:0] dist2;
  logic       in_disc;
  logic       in_crown;
  logic       has_piece;
  logic       is_king;
  logic [23:0] bg_rgb;
  logic [23:0] disc_rgb;

  // Distance-squared from the disc centre; max 49+49 so 8 bits never overflow.
  always_comb begin
    dx       = (lx >= DISC_C) ? (lx - DISC_C) : (DISC_C - lx);
    dy       = (ly >= DISC_C) ? (ly - DISC_C) : (DISC_C - ly);
    dist2    = ({4'd0, dx} * {4'd0, dx}) + ({4'd0, dy} * {4'd0, dy});
    in_disc  = (dist2 <= 8'(DISC_R2));
    in_crown = (lx >= CROWN_LO) && (lx <= CROWN_HI) &&
               (ly >= CROWN_LO) && (ly <= CROWN_HI);
  end

  // Decode the square code into background, piece presence and piece colour.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    bg_rgb    = COL_DARK;
    disc_rgb  = COL_RSVD;
    has_piece = 1'b1;
    is_king   = 1'b0;
    case (code)
      SQ_LIGHT:   begin bg_rgb = COL_LIGHT; has_piece = 1'b0; end
      SQ_DARK:    has_piece = 1'b0;
      SQ_P1_MAN:  disc_rgb = COL_P1;
      SQ_P2_MAN:  disc_rgb = COL_P2;
      SQ_P1_KING: begin disc_rgb = COL_P1; is_king = 1'b1; end
      SQ_P2_KING: begin disc_rgb = COL_P2; is_king = 1'b1; end
      default:    disc_rgb = COL_RSVD;
    endcase
  end

  // Layering: black margin, then crown over disc over background.
  always_comb begin
    if (!in_board)                          pix_rgb = COL_BLACK;
    else if (has_piece && is_king && in_crown) pix_rgb = COL_KING;
    else if (has_piece && in_disc)          pix_rgb = disc_rgb;
    else                                    pix_rgb = bg_rgb;
  end

endmodule

// File: rtl/board_renderer.sv
// Renders a snapshot of a checkers board into a 160x120 frame buffer, one
// pixel per cycle in raster order. Square index and local coordinates come
// from wrapping sub-counters so no divider is needed.
module board_renderer
  import board_renderer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] board,
  output logic [14:0]  wr_addr,
  output logic [23:0]  wr_data,
  output logic         wr_en,
  output logic         busy,
  output logic         done
);

  state_e        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [3:0]    lx_q, lx_d;
  logic [3:0]    ly_q, ly_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;
  logic [14:0]   pix_q, pix_d;
  logic [191:0]  snap_q, snap_d;
  logic          wr_en_q, wr_en_d;
  logic [14:0]   wr_addr_q, wr_addr_d;
  logic [23:0]   wr_data_q, wr_data_d;
  logic          done_q, done_d;

  logic [191:0]  src_board;
  logic [5:0]    sq_rev;
  logic [7:0]    code_lsb;
  logic [2:0]    code;
  logic          in_board;
  logic [23:0]   shade_rgb;
  logic          emit;

  // Pixel 0 is emitted on the start edge itself, before the snapshot is
  // loaded, so it is shaded straight from the board input.
  always_comb begin
    src_board = (state_q == ST_IDLE) ? board : snap_q;
    sq_rev    = 6'd63 - {row_q, col_q};
    code_lsb  = {2'b00, sq_rev} * 8'd3;
    code      = src_board[code_lsb +: 3];
    in_board  = (x_q >= X_BOARD_LO) && (x_q <= X_BOARD_HI);
  end

  board_pixel_shader u_shader (
    .code     (code),
    .lx       (lx_q),
    .ly       (ly_q),
    .in_board (in_board),
    .pix_rgb  (shade_rgb)
  );

  // FSM next state, output registers and raster counter advance.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = pix_q;
    snap_d    = snap_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    emit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RENDER;
          snap_d  = board;
          emit    = 1'b1;
        end
      end
      ST_RENDER: begin
        if (wr_addr_q == PIX_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
        lx_d    = '0;
        ly_d    = '0;
        col_d   = '0;
        row_d   = '0;
        pix_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pix_q;
      wr_data_d = shade_rgb;
      pix_d     = (pix_q == PIX_LAST) ? 15'd0 : pix_q + 15'd1;
      if (x_q == X_MAX) begin
        x_d   = '0;
        lx_d  = '0;
        col_d = '0;
        if (y_q == Y_MAX) begin
          y_d   = '0;
          ly_d  = '0;
          row_d = '0;
        end else if (ly_q == SQ_MAX) begin
          y_d   = y_q + 7'd1;
          ly_d  = '0;
          row_d = row_q + 3'd1;
        end else begin
          y_d  = y_q + 7'd1;
          ly_d = ly_q + 4'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
        if (in_board && (x_q != X_BOARD_HI)) begin
          if (lx_q == SQ_MAX) begin
            lx_d  = '0;
            col_d = col_q + 3'd1;
          end else begin
            lx_d = lx_q + 4'd1;
          end
        end else begin
          lx_d  = '0;
          col_d = '0;
        end
      end
    end
  end

  // State, counters, snapshot and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      lx_q      <= '0;
      ly_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pix_q     <= '0;
      // NOTE: the snapshot is a plain register bank, not a RAM, so it can be
      // cleared by reset like any other flop.
      snap_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge regardless of statement order.
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pix_q     <= pix_d;
      snap_q    <= snap_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: stimulus pushes expected pixels into a
// queue, a negedge monitor pops and compares them as writes appear and checks
// write sequencing and done timing for every completed frame.
module tb_board_renderer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [191:0] board = '0;
  logic [14:0]  wr_addr;
  logic [23:0]  wr_data;
  logic         wr_en;
  logic         busy;
  logic         done;

  board_renderer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .board   (board),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .busy    (busy),
    .done    (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          addr;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  time  t0 = 0;
  int   cur = 0;
  int   wr_cnt = 0;
  int   last_addr = -1;
  int   seq_err = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_px(input int x, input int y, input logic [23:0] rgb);
    exp_t e;
    e.addr = y * 160 + x;
    e.rgb  = rgb;
    exp_q.push_back(e);
  endtask

  function automatic logic [191:0] checkers_board();
    logic [191:0] b;
    logic [2:0]   c;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      int r, k;
      r = i / 8;
      k = i % 8;
      if (((r + k) % 2) == 0) c = 3'b000;
      else if (r < 3)         c = 3'b010;
      else if (r > 4)         c = 3'b001;
      else                    c = 3'b111;
      b[189 - 3 * i +: 3] = c;
    end
    return b;
  endfunction

  function automatic logic [191:0] fill_board(input logic [2:0] c);
    logic [191:0] b;
    for (int i = 0; i < 64; i++) b[3 * i +: 3] = c;
    return b;
  endfunction

  // Called #1 after a posedge: raise start, let the next edge (edge 0) sample it.
  task automatic begin_render();
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    start = 1'b0;
    cur = 1;
  endtask

  // Move to cycle n of the current render (#1 after edge n-1).
  task automatic goto(input int n);
    repeat (n - cur) @(posedge clk);
    #1;
    cur = n;
  endtask

  // Monitor: compare scoreboard pixels, track sequencing and frame completion.
  always @(negedge clk) begin
    int   cyc;
    exp_t e;
    cyc = int'(($time - t0 - 10) / 20) + 1;
    if (!rst) begin
      wr_cnt    = 0;
      last_addr = -1;
      seq_err   = 0;
    end else begin
      if (wr_en) begin
        if (wr_cnt == 0) begin
          check("first_addr", 64'(wr_addr), 64'd0);
          check("first_cycle", 64'(cyc), 64'd1);
        end else if (int'(wr_addr) != last_addr + 1) begin
          seq_err++;
        end
        last_addr = int'(wr_addr);
        wr_cnt++;
        if (exp_q.size() > 0 && int'(wr_addr) == exp_q[0].addr) begin
          e = exp_q.pop_front();
          check($sformatf("pixel_addr_%0d", e.addr), 64'(wr_data), 64'(e.rgb));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", 64'(cyc), 64'd19201);
        check("frame_writes", 64'(wr_cnt), 64'd19200);
        check("last_addr", 64'(last_addr), 64'd19199);
        check("addr_sequence_errors", 64'(seq_err), 64'd0);
        check("busy_at_done", 64'(busy), 64'd1);
        check("wr_en_at_done", 64'(wr_en), 64'd0);
        wr_cnt    = 0;
        last_addr = -1;
        seq_err   = 0;
      end
    end
  end

  initial begin
    logic [191:0] b63;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Abort mid-render with reset, then confirm the block sits idle.
    board = checkers_board();
    begin_render();
    goto(5000);
    rst = 1'b0;
    #1;
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wr_addr", 64'(wr_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_abort_busy", 64'(busy), 64'd0);
    check("idle_after_abort_writes", 64'(wr_cnt), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // Checkers layout; ignored starts at cycles 50 and 19201; board cleared at cycle 100.
    expect_px(0, 0, 24'h000000);
    expect_px(27, 7, 24'hF0D9B5);
    expect_px(42, 7, 24'hFFFFFF);
    expect_px(27, 112, 24'hFF0000);
    begin_render();
    check("busy_cycle1", 64'(busy), 64'd1);
    goto(50);
    start = 1'b1;
    goto(51);
    start = 1'b0;
    goto(100);
    board = fill_board(3'b000);
    goto(19201);
    start = 1'b1;
    goto(19202);
    start = 1'b0;
    check("idle_after_done_busy", 64'(busy), 64'd0);
    goto(19230);
    check("no_extra_writes", 64'(wr_cnt), 64'd0);
    check("frame1_done_count", 64'(done_cnt), 64'd1);
    check("frame1_queue_drained", 64'(exp_q.size()), 64'd0);

    // All P1 kings, then a back-to-back render with a reserved code in square 63.
    board = fill_board(3'b011);
    expect_px(21, 1, 24'h769656);
    expect_px(24, 7, 24'hFF0000);
    expect_px(27, 7, 24'hFFD700);
    begin_render();
    goto(19202);
    b63 = '0;
    b63[2:0] = 3'b101;
    board = b63;
    expect_px(27, 7, 24'hF0D9B5);
    expect_px(132, 112, 24'hFF00FF);
    begin_render();
    check("back_to_back_busy", 64'(busy), 64'd1);
    goto(19203);
    check("frame3_done_count", 64'(done_cnt), 64'd3);
    check("frame3_queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-low, and clock clk.
REQ-002 Port clk, input, 1 bit: 50 MHz system clock.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: one-cycle render request.
REQ-005 Port board, input, 192 bits: 64 squares x 3 bits.
- Square i = row*8+col, with row 0 at the top and col 0 at the left.
- Square i occupies board[191-3i : 189-3i].
REQ-006 Port wr_addr, output, 15 bits: frame-buffer address, equal to y*160+x.
REQ-007 Port wr_data, output, 24 bits: RGB888 pixel value.
REQ-008 Port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-009 Port busy, output, 1 bit: high while a render is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse when a render completes.

Function
REQ-011 The frame SHALL be a 160x120 virtual-pixel frame, rendered in raster order (y outer, x inner), one pixel per cycle.
REQ-012 The board area SHALL be x 20..139 by y 0..119, made of 15x15-pixel squares.
- Square col = (x-20)/15, row = y/15.
- Local coordinates lx = (x-20)%15 and ly = y%15.
- Division and modulo SHALL be implemented with incrementing sub-counters, not dividers.
REQ-013 Pixels with x<20 or x>139 SHALL be written as 0x000000.
REQ-014 Square codes SHALL be:
- 000 light square
- 111 empty dark square
- 001 P1 man
- 010 P2 man
- 011 P1 king
- 100 P2 king
- 101/110 reserved
REQ-015 Background colour SHALL be 0xF0D9B5 for light squares (code 000) and 0x769656 for all other codes.
REQ-016 The piece disc SHALL be the pixels with (lx-7)^2+(ly-7)^2 <= 25.
- Disc colour: 0xFF0000 for P1 codes, 0xFFFFFF for P2 codes, 0xFF00FF for reserved codes.
- Arithmetic SHALL be unsigned, 4-bit operands, 8-bit sum, with no overflow.
REQ-017 For king codes, pixels with lx and ly both in 6..8 SHALL be 0xFFD700, overriding the disc colour.
REQ-018 The FSM SHALL have three states: IDLE, RENDER, DONE.
- IDLE to RENDER: when start=1.
- RENDER to DONE: after the write of pixel 19199.
- DONE to IDLE: unconditionally.
REQ-019 On the start edge, board SHALL be latched into an internal snapshot; later changes to board SHALL NOT affect the frame being rendered.
REQ-020 Output timing SHALL be as follows, with start sampled at edge 0:
- wr_en=1 for exactly 19200 consecutive cycles, 1..19200, with wr_addr running 0..19199.
- done=1 in cycle 19201.
- busy=1 in cycles 1..19201.
REQ-021 wr_addr, wr_data and wr_en SHALL be registered and mutually aligned in the same cycle.
REQ-022 The start input SHALL be ignored while busy=1; a start arriving in the DONE cycle SHALL also be ignored.
REQ-023 Back-to-back renders SHALL be possible: a start in the first IDLE cycle after done SHALL be accepted.
REQ-024 wr_addr SHALL NOT exceed 19199; no wrap-around write SHALL occur.

Reset
REQ-025 While rst=0, the block SHALL hold:
- state IDLE
- wr_en=0, busy=0, done=0
- wr_addr=0, wr_data=0
- counters and snapshot cleared to 0
REQ-026 Reset asserted mid-render SHALL abort the render immediately: no further writes and no done pulse.
REQ-027 After reset release, the block SHALL wait in IDLE for the next start.

Structure
REQ-028 A shared package SHALL hold:
- the square-code constants
- the colour constants
- the geometry constants: FRAME_W=160, FRAME_H=120, BOARD_X0=20, SQ=15, DISC_R2=25
REQ-029 A combinational sub-module board_pixel_shader SHALL map (code, lx, ly, in_board) to wr_data; the FSM, counters and snapshot SHALL reside in board_renderer.

Verification
REQ-030 Power-on checkers layout, start pulse -> 19200 writes.
- Pixel (27,7), square 0 (code 000): 0xF0D9B5.
- Pixel (42,7), square 1 (code 010): 0xFFFFFF.
- Pixel (0,0): 0x000000.
- done in cycle 19201.
REQ-031 All squares 011 -> pixel (27,7) = 0xFFD700, pixel (24,7) = 0xFF0000, pixel (21,1) = 0x769656.
REQ-032 Board changed to all 000 at cycle 100 of a render -> the frame still matches the snapshot taken at start.
REQ-033 Start pulsed at cycles 50 and 19201 -> both pulses ignored; only 19200 writes occur.
REQ-034 rst=0 at cycle 5000 -> wr_en=0 at once, no done; a new start then renders a full frame from address 0.
REQ-035 Reserved code 101 in square 63 -> pixel (132,112) = 0xFF00FF; last write at address 19199, followed by done.
